// File: rtl/rx_uart_if.sv
// Bus-side handshake bundle for the console UART receiver: divisor, pop
// request, FIFO head and the one-cycle error pulses.
`timescale 1ns/1ps

interface rx_uart_if;
   logic [15:0] div;
   logic        rd;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        frame_err;
   logic        overrun;

   modport master (
      output div,
      output rd,
      input  rx_data,
      input  rx_valid,
      input  frame_err,
      input  overrun
   );

   modport slave (
      input  div,
      input  rd,
      output rx_data,
      output rx_valid,
      output frame_err,
      output overrun
   );
endinterface

// File: rtl/rx_uart.sv
// 8N1 serial receiver: two-flop synchronizer, mid-bit sampling FSM and a
// show-ahead receive FIFO. Shares the transmitter's divisor programming.
`timescale 1ns/1ps

module rx_uart #(
   parameter int unsigned SYSTEM_CLK = 100_000_000,
   parameter int unsigned BAUDRATE   = 9600,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic      clk,
   input  logic      resetn,
   input  logic      rx_in,
   rx_uart_if.slave  bus
);

   localparam int unsigned AW      = $clog2(FIFO_DEPTH);
   localparam logic [15:0] DEF_CPS = 16'((SYSTEM_CLK + BAUDRATE / 2) / BAUDRATE);
   localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_BREAK = 3'd4
   } state_t;

   // Divisors below 4 leave no room for a usable half-bit offset.
   function automatic logic [15:0] cps_f(input logic [15:0] d);
      logic [15:0] c;
      if (d == 16'd0) begin
         c = DEF_CPS;
      end else if (d < 16'd4) begin
         c = 16'd4;
      end else begin
         c = d;
      end
      return c;
   endfunction

   logic        s1_r;
   logic        rx_s_r;
   state_t      state_r;
   logic [15:0] cnt_r;
   logic [2:0]  bit_idx_r;
   logic [7:0]  shift_r;
   logic        frame_err_r;

   logic [15:0] cps_s;
   logic [15:0] half_s;
   logic        push_s;

   logic [7:0]  mem_r [FIFO_DEPTH];
   logic [AW:0] wr_ptr_r;
   logic [AW:0] rd_ptr_r;
   logic [AW:0] wr_ptr_nxt_s;
   logic [AW:0] rd_ptr_nxt_s;
   logic        full_s;
   logic        pop_s;
   logic        wr_en_s;
   logic        ovf_s;
   logic [7:0]  rx_data_r;
   logic        rx_valid_r;
   logic        overrun_r;

   // Bit timing and end-of-frame push strobe.
   always_comb begin
      cps_s  = cps_f(bus.div);
      half_s = cps_s >> 1;
      push_s = (state_r == ST_STOP) && (cnt_r == 16'd0) && rx_s_r;
   end

   // Two-flop synchronizer for the asynchronous serial line.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         s1_r   <= 1'b1;
         rx_s_r <= 1'b1;
      end else begin
         s1_r   <= rx_in;
         rx_s_r <= s1_r;
      end
   end

   // Frame recovery FSM: counter loads place every sample at mid-bit.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_r     <= ST_IDLE;
         cnt_r       <= 16'd0;
         bit_idx_r   <= 3'd0;
         shift_r     <= 8'd0;
         frame_err_r <= 1'b0;
      end else begin
         frame_err_r <= 1'b0;
         if (cnt_r != 16'd0) begin
            cnt_r <= cnt_r - 16'd1;
         end
         case (state_r)
            ST_IDLE: begin
               if (!rx_s_r) begin
                  cnt_r   <= half_s - 16'd1;
                  state_r <= ST_START;
               end
            end
            ST_START: begin
               if (cnt_r == 16'd0) begin
                  if (!rx_s_r) begin
                     bit_idx_r <= 3'd0;
                     cnt_r     <= cps_s - 16'd1;
                     state_r   <= ST_DATA;
                  end else begin
                     state_r <= ST_IDLE;
                  end
               end
            end
            ST_DATA: begin
               if (cnt_r == 16'd0) begin
                  shift_r   <= {rx_s_r, shift_r[7:1]};
                  bit_idx_r <= bit_idx_r + 3'd1;
                  cnt_r     <= cps_s - 16'd1;
                  if (bit_idx_r == 3'd7) begin
                     state_r <= ST_STOP;
                  end
               end
            end
            ST_STOP: begin
               // Leave at mid-stop so a start bit right behind it is caught.
               if (cnt_r == 16'd0) begin
                  if (rx_s_r) begin
                     state_r <= ST_IDLE;
                  end else begin
                     frame_err_r <= 1'b1;
                     state_r     <= ST_BREAK;
                  end
               end
            end
            ST_BREAK: begin
               if (rx_s_r) begin
                  state_r <= ST_IDLE;
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   // FIFO bookkeeping; a same-cycle pop frees the slot a full push needs.
   always_comb begin
      full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
      pop_s   = bus.rd & rx_valid_r;
      wr_en_s = push_s & (~full_s | pop_s);
      ovf_s   = push_s & full_s & ~pop_s;
      if (wr_en_s) begin
         wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
      end else begin
         wr_ptr_nxt_s = wr_ptr_r;
      end
      if (pop_s) begin
         rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
      end else begin
         rd_ptr_nxt_s = rd_ptr_r;
      end
   end

   // FIFO storage with registered head byte, valid flag and overrun pulse.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         mem_r      <= '{default: 8'd0};
         wr_ptr_r   <= '0;
         rd_ptr_r   <= '0;
         rx_data_r  <= 8'd0;
         rx_valid_r <= 1'b0;
         overrun_r  <= 1'b0;
      end else begin
         if (wr_en_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= shift_r;
         end
         wr_ptr_r   <= wr_ptr_nxt_s;
         rd_ptr_r   <= rd_ptr_nxt_s;
         rx_valid_r <= (wr_ptr_nxt_s != rd_ptr_nxt_s);
         overrun_r  <= ovf_s;
         // Head bypass: a byte written into the slot that becomes the head.
         if (wr_en_s && (wr_ptr_r[AW-1:0] == rd_ptr_nxt_s[AW-1:0])) begin
            rx_data_r <= shift_r;
         end else begin
            rx_data_r <= mem_r[rd_ptr_nxt_s[AW-1:0]];
         end
      end
   end

   assign bus.rx_data   = rx_data_r;
   assign bus.rx_valid  = rx_valid_r;
   assign bus.frame_err = frame_err_r;
   assign bus.overrun   = overrun_r;

endmodule

// File: tb/tb_rx_uart.sv
// Directed bench for rx_uart: framing, glitch rejection, break handling,
// FIFO overrun, default divisor and mid-frame reset.
`timescale 1ns/1ps

module tb_rx_uart;

   logic clk    = 1'b0;
   logic resetn = 1'b0;
   logic rx_in  = 1'b1;

   int n_checks = 0;
   int n_pass   = 0;
   int fe_cnt   = 0;
   int ov_cnt   = 0;
   int lat;
   logic got;
   int fe_base;
   int ov_base;

   rx_uart_if bus ();

   rx_uart #(
      .SYSTEM_CLK (100_000_000),
      .BAUDRATE   (115200),
      .FIFO_DEPTH (4)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .rx_in  (rx_in),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   // Count error pulses, sampled away from the active edge.
   always @(negedge clk) begin
      if (bus.frame_err) fe_cnt <= fe_cnt + 1;
      if (bus.overrun)   ov_cnt <= ov_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input int cps, input logic stop_v);
      rx_in = 1'b0;
      repeat (cps) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx_in = b[i];
         repeat (cps) @(negedge clk);
      end
      rx_in = stop_v;
      repeat (cps) @(negedge clk);
   endtask

   task automatic idle(input int n);
      rx_in = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic pop_check(input string tag, input logic [7:0] exp);
      check($sformatf("%s_valid", tag), 32'(bus.rx_valid), 32'd1);
      check($sformatf("%s_data", tag), 32'(bus.rx_data), 32'(exp));
      bus.rd = 1'b1;
      @(negedge clk);
      bus.rd = 1'b0;
   endtask

   initial begin
      bus.div = 16'd16;
      bus.rd  = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_valid", 32'(bus.rx_valid), 32'd0);
      check("rst_data", 32'(bus.rx_data), 32'd0);
      check("rst_ferr", 32'(bus.frame_err), 32'd0);
      check("rst_ovr", 32'(bus.overrun), 32'd0);
      resetn = 1'b1;
      idle(5);

      // Back-to-back 0xA5, 0x3C at CPS 16: latency 2+8+144 from E0.
      lat = 0;
      got = 1'b0;
      fork
         begin
            send_frame(8'hA5, 16, 1'b1);
            send_frame(8'h3C, 16, 1'b1);
         end
         begin
            while (!got && lat < 400) begin
               @(posedge clk);
               lat++;
               @(negedge clk);
               got = bus.rx_valid;
            end
         end
      join
      check("latency_in_window", 32'((lat - 1 >= 153) && (lat - 1 <= 155)), 32'd1);
      idle(16);
      pop_check("b2b_a5", 8'hA5);
      pop_check("b2b_3c", 8'h3C);
      check("b2b_empty", 32'(bus.rx_valid), 32'd0);
      check("b2b_ferr_cnt", 32'(fe_cnt), 32'd0);
      check("b2b_ovr_cnt", 32'(ov_cnt), 32'd0);

      // Three-cycle glitch is a false start, then a clean 0x00 frame.
      rx_in = 1'b0;
      repeat (3) @(negedge clk);
      idle(30);
      check("glitch_nopush", 32'(bus.rx_valid), 32'd0);
      check("glitch_ferr_cnt", 32'(fe_cnt), 32'd0);
      send_frame(8'h00, 16, 1'b1);
      idle(8);
      pop_check("after_glitch_00", 8'h00);
      check("glitch_empty", 32'(bus.rx_valid), 32'd0);

      // 0x55 with a low stop bit and the line held low: one frame_err only.
      send_frame(8'h55, 16, 1'b0);
      repeat (40) @(negedge clk);
      check("break_ferr_cnt", 32'(fe_cnt), 32'd1);
      check("break_nopush", 32'(bus.rx_valid), 32'd0);
      idle(16);
      send_frame(8'h81, 16, 1'b1);
      idle(8);
      pop_check("after_break_81", 8'h81);
      check("break_ferr_once", 32'(fe_cnt), 32'd1);

      // Five frames into a 4-deep FIFO with no pops.
      bus.div = 16'd8;
      for (int k = 1; k <= 5; k++) begin
         send_frame(8'(k), 8, 1'b1);
         check($sformatf("ovr_after_frame%0d", k), 32'(ov_cnt), (k == 5) ? 32'd1 : 32'd0);
      end
      idle(8);
      for (int k = 1; k <= 4; k++) begin
         pop_check($sformatf("ovr_pop%0d", k), 8'(k));
      end
      check("ovr_empty", 32'(bus.rx_valid), 32'd0);

      // Full FIFO, pop lands on the 5th stop-sample edge: no overrun.
      for (int k = 1; k <= 4; k++) begin
         send_frame(8'(k), 8, 1'b1);
      end
      fork
         send_frame(8'h05, 8, 1'b1);
         begin
            repeat (78) @(negedge clk);
            bus.rd = 1'b1;
            @(negedge clk);
            bus.rd = 1'b0;
         end
      join
      check("fullpop_no_ovr", 32'(ov_cnt), 32'd1);
      idle(8);
      for (int k = 2; k <= 5; k++) begin
         pop_check($sformatf("fullpop_pop%0d", k), 8'(k));
      end
      check("fullpop_empty", 32'(bus.rx_valid), 32'd0);

      // Default divisor (CPS 868), then reset during bit 4 of the next frame.
      bus.div = 16'd0;
      fe_base = fe_cnt;
      ov_base = ov_cnt;
      send_frame(8'hC3, 868, 1'b1);
      idle(20);
      check("div0_c3_valid", 32'(bus.rx_valid), 32'd1);
      check("div0_c3_data", 32'(bus.rx_data), 32'hC3);
      fork
         send_frame(8'hF0, 868, 1'b1);
         begin
            repeat (4774) @(negedge clk);
            resetn = 1'b0;
            @(negedge clk);
            resetn = 1'b1;
            check("midrst_valid", 32'(bus.rx_valid), 32'd0);
            check("midrst_ferr", 32'(bus.frame_err), 32'd0);
            check("midrst_ovr", 32'(bus.overrun), 32'd0);
         end
      join
      idle(868);
      send_frame(8'h7E, 868, 1'b1);
      idle(8);
      pop_check("after_rst_7e", 8'h7E);
      check("after_rst_empty", 32'(bus.rx_valid), 32'd0);
      check("div0_ferr_cnt", 32'(fe_cnt), 32'(fe_base));
      check("div0_ovr_cnt", 32'(ov_cnt), 32'(ov_base));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/rx_uart.md
# rx_uart

Asynchronous serial receiver for the SoC console/debug UART, the receive side of the existing 8N1 transmitter. It samples an idle-high `rx_in` line, recovers 8-bit LSB-first frames (1 start, 8 data, 1 stop), and buffers completed bytes in a small show-ahead FIFO that the bus/MMIO side reads. It uses the same `div` programming as the transmitter, so one divisor register drives both directions.

## Interface
- `SYSTEM_CLK`, 100_000_000: clk frequency in Hz.
- `BAUDRATE`, 9600: default baud rate, used when `div == 0`.
- `FIFO_DEPTH`, 4: receive FIFO entries; power of two, ≥ 2.

- `clk`, input, 1: clock.
- `resetn`, input, 1: reset. Synchronous, active-low.
- `rx_in`, input, 1: asynchronous serial line, idle high.
- `div`, input, 16: clk cycles per bit. 0 selects the default.
- `rd`, input, 1: pop request. Ignored while `rx_valid` is 0.
- `rx_data`, output, 8: FIFO head byte. Valid while `rx_valid` is 1.
- `rx_valid`, output, 1: FIFO not empty.
- `frame_err`, output, 1: one-cycle pulse; stop bit sampled as 0.
- `overrun`, output, 1: one-cycle pulse; good byte dropped because the FIFO was full.

## Operation
- CPS (cycles per symbol):
  - `div == 0`: (SYSTEM_CLK + BAUDRATE/2) / BAUDRATE, integer division.
  - `div` of 1–3: clamped to 4.
  - Otherwise: `div`.
  - H = CPS >> 1.
  - CPS is re-evaluated on every counter load. Changing `div` mid-frame is allowed but gives undefined data.
- Synchronizer: two flops, `rx_in` → `s1` → `rx_s`. All FSM decisions use `rx_s` only.
- Bit counter, 16 bits. When loaded with L on edge k, it reaches 0 after edge k+L. The sample is taken on the next edge, k+L+1, where counter == 0.
- FSM states:
  - IDLE (0): if `rx_s == 0`, load H-1 and go to START.
  - START (1): at counter 0, if `rx_s == 0`, clear `bit_idx`, load CPS-1, go to DATA. Otherwise it is a false start: go to IDLE with no flag.
  - DATA (2): at counter 0, shift `rx_s` into the MSB of the shift register (shift right), increment `bit_idx`, load CPS-1. After the 8th sample (`bit_idx == 7`), go to STOP.
  - STOP (3): at counter 0:
    - `rx_s == 1`: push the byte (or pulse `overrun`), go to IDLE.
    - `rx_s == 0`: pulse `frame_err`, discard the byte, go to BREAK.
  - BREAK (4): wait for `rx_s == 1`, then go to IDLE. This prevents a held-low line from being read as repeated 0x00 frames.
  - Undefined encodings go to IDLE.
- The FSM returns to IDLE at mid-stop-bit, so a start bit immediately following the stop bit is caught.
- FIFO:
  - Show-ahead: `rx_data` = mem[rd_ptr].
  - Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally. Full is defined as MSBs differing with the lower bits equal.
  - Push when full:
    - Same-cycle pop (`rd & rx_valid`): the push is accepted and the count is unchanged.
    - No pop: the byte is dropped and `overrun` pulses.
  - Push and pop in the same cycle when not full: both happen and the count is unchanged.
- Reset (`resetn == 0` at a clk edge):
  - Synchronizer flops set to 1.
  - State IDLE; counter, `bit_idx` and shift register cleared; FIFO pointers cleared.
  - `rx_valid` = 0, `frame_err` = 0, `overrun` = 0. `rx_data` is don't-care; it reads 0 from the cleared location.
  - Reset mid-frame abandons the frame. The remainder of that frame may be misread as a new start; this is accepted.

## Timing
- `rx_in` falls before edge E0; IDLE detects it at E2.
- Start sample: E2+H. Data bit i (i = 0..7): E2+H+(i+1)·CPS. Stop sample: E2+H+9·CPS.
- `rx_valid` rises in the cycle after the stop-sample edge. Total latency is 2+H+9·CPS cycles from E0.
- `frame_err` and `overrun` are high for exactly the cycle after the stop-sample edge.
- `rd` pop is effective at the edge. The next byte, or `rx_valid` = 0, appears the following cycle. No combinational path from `rd` to outputs.

## Test plan
- `div` = 16, line sends 0xA5 then 0x3C back-to-back with no idle gap → `rx_valid` within 2+8+144 ±1 cycles of the first falling edge. Pops return 0xA5 then 0x3C; no error pulses.
- `div` = 16, a 3-cycle low glitch on an idle line → no push, no `frame_err`, FSM back in IDLE. A following 0x00 frame is received correctly.
- `div` = 16, frame 0x55 with the stop bit driven 0 and the line held low 40 cycles → exactly one `frame_err` pulse, no push. After the line returns high, 0x81 is received correctly.
- FIFO_DEPTH = 4, `div` = 8, 5 frames 0x01..0x05 sent with `rd` low → `overrun` pulses once, on the 5th stop sample. Pops yield 0x01..0x04, then `rx_valid` = 0.
- FIFO full, with `rd` asserted on the same cycle as the 5th stop sample → no `overrun`. Pops yield 0x02..0x05.
- `div` = 0 with SYSTEM_CLK = 100 MHz, BAUDRATE = 115200 (CPS = 868), byte 0xC3 → received correctly. Then `resetn` pulsed low during bit 4 of the next frame → `rx_valid` = 0 and no error pulse during the reset cycle; a frame 0x7E sent after a full idle bit time is received correctly.
